game_stage_controller: RTL and testbench
========================================

GAME_STAGE_CONTROLLER -- requirements
Module: game_stage_controller

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of stages; the last stage is the boss stage (stage_num 4 with the default).
REQ-002 Parameter CLEAR_DELAY_FRAMES, default 60, number of frames the game pauses between stages.
REQ-003 Parameter INITIAL_LIVES, default 3, player lives at game start.
REQ-004 Parameter POINTS_PER_KILL, default 1, score increment per monster death.
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  asynchronous active-low reset.
REQ-007 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-008 start_key  in  1  level input from the keyboard decoder; start/restart request.
REQ-009 monster_died_pulse  in  1  one-cycle pulse from the monsters block.
REQ-010 all_monsters_dead  in  1  level input from the monsters block.
REQ-011 player_dead_pulse  in  1  one-cycle pulse when the player is hit.
REQ-012 stage_num  out  3  current stage 1..NUM_STAGES; 0 when not in play.
REQ-013 monsters_enable  out  1  gates movement and shooting of the monsters.
REQ-014 stage_resetN  out  1  active-low synchronous restart of the monsters and missiles for a new stage.
REQ-015 score  out  16  unsigned binary score.
REQ-016 lives  out  3  remaining lives.
REQ-017 game_won, game_over  out  1 each  status levels for the display.

Function
REQ-018 The FSM SHALL use states IDLE, LOAD, PLAYING, CLEAR, WIN and OVER.
REQ-019 A start_key rising edge is detected on the registered start_key. On that edge in IDLE, WIN or OVER, the block SHALL set stage 1, score to 0 and lives to INITIAL_LIVES, then go to LOAD.
REQ-020 LOAD SHALL last exactly one clk cycle with stage_resetN=0, then go to PLAYING. stage_resetN SHALL be 1 in every other state.
REQ-021 In PLAYING, monsters_enable SHALL be 1. In every other state it SHALL be 0.
REQ-022 all_monsters_dead SHALL be ignored in PLAYING until the first startOfFrame after entry, because the monster status can be stale.
REQ-023 In PLAYING, all_monsters_dead=1 after that first frame SHALL cause a transition:
- to CLEAR if stage_num < NUM_STAGES;
- otherwise to WIN.
REQ-024 CLEAR SHALL count CLEAR_DELAY_FRAMES startOfFrame pulses, then increment stage_num and go to LOAD.
REQ-025 Each monster_died_pulse in PLAYING SHALL add POINTS_PER_KILL to score, saturating at 16'hFFFF. Pulses in other states SHALL be ignored.
REQ-026 Each player_dead_pulse in PLAYING SHALL decrement lives. If lives was 1, the block SHALL go to OVER with lives=0.
REQ-027 If player_dead_pulse and all_monsters_dead are both valid in the same cycle, the death SHALL be processed first. A resulting OVER SHALL take precedence over CLEAR and WIN.
REQ-028 If monster_died_pulse occurs in the same cycle as a state exit, the score SHALL still be counted.
REQ-029 game_won SHALL be 1 only in WIN. game_over SHALL be 1 only in OVER.
REQ-030 stage_num SHALL be 0 in IDLE. In WIN and OVER it SHALL hold its last value.

Reset
REQ-031 While resetN=0, all outputs SHALL take these values: state IDLE, stage_num 0, score 0, lives INITIAL_LIVES, monsters_enable 0, stage_resetN 1, game_won 0, game_over 0, frame counter 0.
REQ-032 A reset during any state SHALL abort immediately to those values. There SHALL be no pending LOAD pulse after reset.

Configuration
REQ-033 With GAME_STAGE_BONUS_LIFE_EN defined, each time score crosses a multiple of 10 the block SHALL add one life, capped at 7.
REQ-034 Without GAME_STAGE_BONUS_LIFE_EN, lives SHALL never increase, and no extra logic SHALL remain.

Structure
REQ-035 The FSM state enum, the lives cap (7) and the bonus interval (10) SHALL reside in the shared package game_pkg.
REQ-036 The frame counter SHALL be a sub-module named frame_delay_counter with start, startOfFrame and done ports.

Verification
REQ-037 Reset, start_key rise -> one LOAD cycle with stage_resetN=0, then stage_num=1, monsters_enable=1, lives=3, score=0.
REQ-038 Raise all_monsters_dead in stage 1 after one frame -> monsters_enable=0 for exactly 60 frames, then LOAD, then stage_num=2.
REQ-039 all_monsters_dead held high on the first PLAYING cycle, before any startOfFrame -> no transition.
REQ-040 Three player_dead_pulse in PLAYING -> lives 2, 1, 0 and game_over=1. In the same cycle as the third pulse, assert all_monsters_dead -> OVER, not CLEAR.
REQ-041 Clear stage 4 -> game_won=1, stage_num holds 4; start_key rise -> stage 1, score 0.
REQ-042 Preload score 16'hFFFE and send 3 monster_died_pulse -> score 16'hFFFF. With GAME_STAGE_BONUS_LIFE_EN defined, 10 kills from score 0 -> lives 4.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game stage controller: FSM state encoding,
// lives cap and bonus-life score interval.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAYING,
    CLEAR,
    WIN,
    OVER
  } game_state_t;

  localparam logic [2:0] LIVES_CAP      = 3'd7;
  localparam int         BONUS_INTERVAL = 10;

  // True when a score update moved the score past a multiple of BONUS_INTERVAL.
  function automatic logic crosses_bonus(input logic [15:0] old_score,
                                         input logic [15:0] new_score);
    return (int'(new_score) / BONUS_INTERVAL) != (int'(old_score) / BONUS_INTERVAL);
  endfunction

endpackage

// File: rtl/frame_delay_counter.sv
// Counts DELAY_FRAMES startOfFrame pulses after a start request and raises
// done for one cycle on the final pulse. A new start restarts the count.
module frame_delay_counter #(
  parameter int DELAY_FRAMES = 60
) (
  input  logic clk,
  input  logic resetN,
  input  logic start,
  input  logic startOfFrame,
  output logic done
);

  localparam int CW = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;

  logic [CW-1:0] count;
  logic          running;
  logic          last;

  assign last = (count == CW'(DELAY_FRAMES - 1));
  assign done = running & startOfFrame & last;

  // Frame counter: armed by start, advances once per frame, stops after the last frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= '0;
      running <= 1'b1;
    end else if (running && startOfFrame) begin
      if (last) begin
        count   <= '0;
        running <= 1'b0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_stage_controller.sv
// Game stage controller: sequences IDLE -> LOAD -> PLAYING -> CLEAR/WIN/OVER,
// keeps score and lives, and pauses between stages for a number of frames.
// Optional feature: define GAME_STAGE_BONUS_LIFE_EN to grant one extra life
// (capped) each time the score passes a multiple of the bonus interval.
module game_stage_controller
  import game_pkg::*;
#(
  parameter int NUM_STAGES         = 4,
  parameter int CLEAR_DELAY_FRAMES = 60,
  parameter int INITIAL_LIVES      = 3,
  parameter int POINTS_PER_KILL    = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        monster_died_pulse,
  input  logic        all_monsters_dead,
  input  logic        player_dead_pulse,
  output logic [2:0]  stage_num,
  output logic        monsters_enable,
  output logic        stage_resetN,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic        game_won,
  output logic        game_over
);

  game_state_t state, next_state;

  logic        start_key_q;
  logic        start_rise;
  logic        frame_seen;
  logic        clear_start;
  logic        clear_done;
  logic [15:0] score_next;
  logic [2:0]  lives_next;

  assign start_rise = start_key & ~start_key_q;

  // Saturating score increment for one kill.
  function automatic logic [15:0] sat_add_score(input logic [15:0] s);
    logic [16:0] sum;
    sum = {1'b0, s} + 17'(POINTS_PER_KILL);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Score after this cycle's kill, if any.
  always_comb begin
    score_next = score;
    if (monster_died_pulse) score_next = sat_add_score(score);
  end

  // Lives after this cycle's death and (optionally) bonus; the death wins when it empties lives.
  always_comb begin
    lives_next = lives;
    if (player_dead_pulse && lives != 3'd0) lives_next = lives - 3'd1;
`ifdef GAME_STAGE_BONUS_LIFE_EN
    if (monster_died_pulse && crosses_bonus(score, score_next) &&
        !(player_dead_pulse && lives == 3'd1) && lives_next < LIVES_CAP)
      lives_next = lives_next + 3'd1;
`endif
  end

  // Inter-stage pause timer.
  frame_delay_counter #(
    .DELAY_FRAMES(CLEAR_DELAY_FRAMES)
  ) u_clear_delay (
    .clk         (clk),
    .resetN      (resetN),
    .start       (clear_start),
    .startOfFrame(startOfFrame),
    .done        (clear_done)
  );

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state and state-decoded outputs; a fatal death overrides stage completion.
  always_comb begin
    next_state      = state;
    clear_start     = 1'b0;
    monsters_enable = 1'b0;
    stage_resetN    = 1'b1;
    game_won        = 1'b0;
    game_over       = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) next_state = LOAD;
      end
      LOAD: begin
        stage_resetN = 1'b0;
        next_state   = PLAYING;
      end
      PLAYING: begin
        monsters_enable = 1'b1;
        if (player_dead_pulse && lives == 3'd1) begin
          next_state = OVER;
        end else if (frame_seen && all_monsters_dead) begin
          if (stage_num < 3'(NUM_STAGES)) begin
            next_state  = CLEAR;
            clear_start = 1'b1;
          end else begin
            next_state = WIN;
          end
        end
      end
      CLEAR: begin
        if (clear_done) next_state = LOAD;
      end
      WIN: begin
        game_won = 1'b1;
        if (start_rise) next_state = LOAD;
      end
      OVER: begin
        game_over = 1'b1;
        if (start_rise) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Game data: stage, score, lives, key history and the stale-status guard.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      start_key_q <= 1'b0;
      stage_num   <= 3'd0;
      score       <= 16'd0;
      lives       <= 3'(INITIAL_LIVES);
      frame_seen  <= 1'b0;
    end else begin
      start_key_q <= start_key;
      case (state)
        IDLE, WIN, OVER: begin
          if (start_rise) begin
            stage_num <= 3'd1;
            score     <= 16'd0;
            lives     <= 3'(INITIAL_LIVES);
          end
        end
        LOAD: begin
          frame_seen <= 1'b0;
        end
        PLAYING: begin
          if (startOfFrame) frame_seen <= 1'b1;
          score <= score_next;
          lives <= lives_next;
        end
        CLEAR: begin
          if (clear_done) stage_num <= stage_num + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_stage_controller.sv
// Bench for game_stage_controller: rule-level reference model checked every
// cycle, directed scenarios with literal expectations, and a second instance
// with a large kill value to reach score saturation quickly.
module tb_game_stage_controller;

  localparam int NS  = 4;
  localparam int CDF = 60;
  localparam int IL  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN, sof, start_key, kill, amd, dead;
  logic [2:0]  stage_num, lives;
  logic [15:0] score;
  logic        monsters_enable, stage_resetN, game_won, game_over;

  logic        s2_key, s2_kill;
  logic [2:0]  stage_num2, lives2;
  logic [15:0] score2;
  logic        en2, srn2, won2, over2;

  game_stage_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(start_key),
    .monster_died_pulse(kill), .all_monsters_dead(amd), .player_dead_pulse(dead),
    .stage_num(stage_num), .monsters_enable(monsters_enable), .stage_resetN(stage_resetN),
    .score(score), .lives(lives), .game_won(game_won), .game_over(game_over)
  );

  game_stage_controller #(.POINTS_PER_KILL(32767)) dut_sat (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(s2_key),
    .monster_died_pulse(s2_kill), .all_monsters_dead(1'b0), .player_dead_pulse(1'b0),
    .stage_num(stage_num2), .monsters_enable(en2), .stage_resetN(srn2),
    .score(score2), .lives(lives2), .game_won(won2), .game_over(over2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: game phase, stage, score, lives, frames left in the pause.
  localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_CLEAR = 3, M_WIN = 4, M_OVER = 5;
  int m_mode, m_stage, m_score, m_lives, m_left;
  bit m_armed, m_key_q;

  always @(posedge clk or negedge resetN) begin
    bit rise;
    bit gain;
    int old;
    if (!resetN) begin
      m_mode = M_IDLE; m_stage = 0; m_score = 0; m_lives = IL;
      m_left = 0; m_armed = 0; m_key_q = 0;
    end else begin
      rise = start_key && !m_key_q;
      m_key_q = start_key;
      case (m_mode)
        M_IDLE, M_WIN, M_OVER:
          if (rise) begin
            m_stage = 1; m_score = 0; m_lives = IL; m_mode = M_LOAD;
          end
        M_LOAD: begin
          m_mode = M_PLAY; m_armed = 0;
        end
        M_PLAY: begin
          gain = 0;
          if (kill) begin
            old = m_score;
            m_score = (m_score + 1 > 65535) ? 65535 : m_score + 1;
`ifdef GAME_STAGE_BONUS_LIFE_EN
            if (m_score / 10 != old / 10) gain = 1;
`endif
          end
          if (dead && m_lives == 1) begin
            m_lives = 0; m_mode = M_OVER;
          end else begin
            if (dead) m_lives = m_lives - 1;
            if (gain && m_lives < 7) m_lives = m_lives + 1;
          end
          if (m_mode == M_PLAY && m_armed && amd) begin
            if (m_stage < NS) begin m_mode = M_CLEAR; m_left = CDF; end
            else m_mode = M_WIN;
          end
          if (sof) m_armed = 1;
        end
        M_CLEAR:
          if (sof) begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_stage = m_stage + 1; m_mode = M_LOAD; end
          end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    chk("stage_num", int'(stage_num), (m_mode == M_IDLE) ? 0 : m_stage);
    chk("score", int'(score), m_score);
    chk("lives", int'(lives), m_lives);
    chk("monsters_enable", int'(monsters_enable), int'(m_mode == M_PLAY));
    chk("stage_resetN", int'(stage_resetN), int'(m_mode != M_LOAD));
    chk("game_won", int'(game_won), int'(m_mode == M_WIN));
    chk("game_over", int'(game_over), int'(m_mode == M_OVER));
  end

  bit auto_sof;
  int fcnt;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      kill = 0; dead = 0; s2_kill = 0;
      sof = auto_sof && (fcnt == 0);
      fcnt = (fcnt + 1) % 4;
    end
  endtask

  task automatic wait_play(input string name);
    int n;
    n = 0;
    while (!monsters_enable && n < 400) begin tick(1); n++; end
    chk(name, int'(n < 400), 1);
  endtask

  task automatic clear_current(input bit with_kill);
    tick(8);
    amd = 1; kill = with_kill;
    tick(1);
    amd = 0;
  endtask

  initial begin
    int frames, n;
    resetN = 0; sof = 0; start_key = 0; kill = 0; amd = 0; dead = 0;
    s2_key = 0; s2_kill = 0; auto_sof = 0; fcnt = 0;
    tick(3);
    chk("rst_stage", int'(stage_num), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_srn", int'(stage_resetN), 1);
    chk("rst_en", int'(monsters_enable), 0);
    chk("rst_score", int'(score), 0);
    resetN = 1;
    tick(2);

    // Start: one LOAD cycle, then stage 1 in play.
    start_key = 1; tick(1);
    chk("load_srn", int'(stage_resetN), 0);
    chk("load_stage", int'(stage_num), 1);
    tick(1);
    chk("play_srn", int'(stage_resetN), 1);
    chk("play_en", int'(monsters_enable), 1);
    chk("play_lives", int'(lives), 3);
    chk("play_score", int'(score), 0);
    start_key = 0;

    // Stale all-dead status before any frame must be ignored.
    amd = 1; tick(3);
    chk("stale_amd_en", int'(monsters_enable), 1);
    amd = 0;

    // One frame, then clear stage 1 and count the pause frames.
    sof = 1; tick(1); tick(1);
    amd = 1; tick(1); amd = 0;
    chk("clear_en", int'(monsters_enable), 0);
    auto_sof = 1; fcnt = 0; frames = 0; n = 0;
    while (stage_resetN && n < 400) begin
      if (!monsters_enable && sof) frames++;
      tick(1); n++;
    end
    chk("clear_frames", frames, 60);
    chk("after_clear_stage", int'(stage_num), 2);
    tick(1);
    chk("stage2_en", int'(monsters_enable), 1);

    // Stage 2: kills, then a kill in the exit cycle still scores.
    kill = 1; tick(1); tick(2);
    kill = 1; tick(1);
    chk("score_two_kills", int'(score), 2);
    clear_current(1'b1);
    chk("exit_kill_score", int'(score), 3);
    wait_play("wait_stage3");
    chk("stage3", int'(stage_num), 3);
    clear_current(1'b0);
    wait_play("wait_stage4");
    chk("stage4", int'(stage_num), 4);
    clear_current(1'b0);
    chk("won", int'(game_won), 1);
    tick(5);
    chk("won_hold", int'(game_won), 1);
    chk("won_stage_hold", int'(stage_num), 4);

    // Restart from WIN.
    start_key = 1; tick(1);
    chk("restart_stage", int'(stage_num), 1);
    tick(1);
    chk("restart_score", int'(score), 0);
    chk("restart_en", int'(monsters_enable), 1);
    start_key = 0;

    // Three deaths; the last coincides with all-dead and must end the game.
    dead = 1; tick(1);
    chk("lives_after_1", int'(lives), 2);
    dead = 1; tick(1);
    chk("lives_after_2", int'(lives), 1);
    tick(8);
    dead = 1; amd = 1; tick(1); amd = 0;
    chk("lives_after_3", int'(lives), 0);
    chk("over", int'(game_over), 1);
    chk("over_not_won", int'(game_won), 0);
    chk("over_stage_hold", int'(stage_num), 1);

    // Restart from OVER and score ten kills.
    start_key = 1; tick(1); start_key = 0; tick(1);
    repeat (10) begin kill = 1; tick(1); end
    tick(1);
    chk("ten_kills_score", int'(score), 10);
`ifdef GAME_STAGE_BONUS_LIFE_EN
    chk("bonus_lives", int'(lives), 4);
`else
    chk("no_bonus_lives", int'(lives), 3);
`endif

    // Asynchronous reset mid-play.
    #2 resetN = 0;
    #1;
    chk("async_rst_stage", int'(stage_num), 0);
    chk("async_rst_score", int'(score), 0);
    chk("async_rst_en", int'(monsters_enable), 0);
    chk("async_rst_srn", int'(stage_resetN), 1);
    chk("async_rst_lives", int'(lives), 3);
    tick(2);
    resetN = 1;
    tick(3);
    chk("no_pending_load", int'(stage_resetN), 1);
    chk("idle_after_rst", int'(stage_num), 0);

    // Saturation on the large-kill instance.
    s2_key = 1; tick(1); tick(1);
    s2_kill = 1; tick(1);
    s2_kill = 1; tick(1);
    tick(1);
    chk("sat_preload", int'(score2), 65534);
    repeat (3) begin s2_kill = 1; tick(1); end
    tick(1);
    chk("sat_score", int'(score2), 65535);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
